load_store_unit: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store request at a time from the MEM

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/lsu_extend.sv | 27 ++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: data word, access-width
// encodings, FSM state encoding and the alignment rule.
package load_store_unit_pkg;

  localparam int WORD = 32;

  typedef logic [WORD-1:0] word_t;

  // Memory access width as seen on req_mode / mem_mode.
  typedef logic [1:0] mmd_t;

  localparam mmd_t MEM_BYTE = 2'b00;
  localparam mmd_t MEM_HALF = 2'b01;
  localparam mmd_t MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'b00,
    LSU_ACCESS = 2'b01,
    LSU_RESP   = 2'b10
  } lsu_state_t;

  // True when an access cannot be issued: the width encoding is illegal or
  // the address is not a multiple of the access width.
  function automatic logic access_fault(input mmd_t mode, input logic [1:0] addr_lo);
    case (mode)
      MEM_BYTE: access_fault = 1'b0;
      MEM_HALF: access_fault = addr_lo[0];
      MEM_WORD: access_fault = |addr_lo;
      default:  access_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational helper of the load/store unit: flags misaligned or illegal
// accesses and sign/zero-extends right-justified load data to a full word.
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  mmd_t        mode,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  word_t       data,
  output logic        misaligned,
  output word_t       extended
);

  // Alignment check and width-dependent extension of the memory read data.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // it unassigned; an unassigned path in always_comb infers a latch.
    misaligned = access_fault(mode, addr_lo);
    extended   = data;
    case (mode)
      MEM_BYTE: extended = {{24{sign_ext & data[7]}},  data[7:0]};
      MEM_HALF: extended = {{16{sign_ext & data[15]}}, data[15:0]};
      default:  extended = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the data-memory interface. Accepts one load/store at a
// time, rejects misaligned/illegal accesses without touching memory, holds
// the memory strobe for MEM_LATENCY cycles, then pulses a response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_mode,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic [1:0]  mem_mode,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_readData
);

  // Wide enough to hold MEM_LATENCY-1.
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  lsu_state_t    state;
  lsu_state_t    state_nxt;
  logic [CW-1:0] count;

  word_t addr_q;
  word_t wdata_q;
  mmd_t  mode_q;
  logic  write_q;
  logic  signed_q;
  logic  error_q;

  mmd_t  chk_mode;
  logic  [1:0] chk_addr_lo;
  logic  fault;
  word_t extended;

  // In IDLE the helper judges the incoming request; afterwards it works on the
  // latched request so the extension matches what was issued to memory.
  assign chk_mode    = (state == LSU_IDLE) ? req_mode      : mode_q;
  assign chk_addr_lo = (state == LSU_IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_extend u_extend (
    .mode       (chk_mode),
    .sign_ext   (signed_q),
    .addr_lo    (chk_addr_lo),
    .data       (mem_readData),
    .misaligned (fault),
    .extended   (extended)
  );

  // State register; reset drops the state, which in turn drops the strobes
  // asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state <= LSU_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE, or IDLE -> RESP on fault.
  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE:   if (req_valid) state_nxt = fault ? LSU_RESP : LSU_ACCESS;
      LSU_ACCESS: if (count == '0) state_nxt = LSU_RESP;
      LSU_RESP:   state_nxt = LSU_IDLE;
      default:    state_nxt = LSU_IDLE;
    endcase
  end

  // Request latches, latency counter and load-data capture.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: these registers drive the memory bus and response outputs, which
    // must read zero out of reset, so they are reset like control state.
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      mode_q     <= MEM_BYTE;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      error_q    <= 1'b0;
      count      <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            mode_q     <= req_mode;
            write_q    <= req_write;
            signed_q   <= req_signed;
            error_q    <= fault;
            count      <= CW'(MEM_LATENCY - 1);
            resp_rdata <= '0;
          end
        end
        LSU_ACCESS: begin
          if (count == '0) begin
            if (!write_q) resp_rdata <= extended;
          end else begin
            count <= count - CW'(1);
          end
        end
        LSU_RESP: resp_rdata <= '0;
        default:  resp_rdata <= '0;
      endcase
    end
  end

  assign req_ready     = (state == LSU_IDLE);
  assign resp_valid    = (state == LSU_RESP);
  assign resp_error    = resp_valid & error_q;
  assign mem_read      = (state == LSU_ACCESS) & ~write_q;
  assign mem_write     = (state == LSU_ACCESS) &  write_q;
  assign mem_address   = addr_q;
  assign mem_writeData = wdata_q;
  assign mem_mode      = mode_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a big-endian byte memory answers the DUT, and a
// reference memory with plain arithmetic predicts every response, strobe
// window and timing. A second instance with MEM_LATENCY=3 covers the longer
// strobe, and a reset is fired into the middle of a store.
module tb_load_store_unit;

  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT with MEM_LATENCY = 1 ----------------
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_writeData, mem_readData;
  logic [1:0]  mem_mode;
  logic        mem_read, mem_write;

  load_store_unit #(.MEM_LATENCY(LAT1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mode(req_mode), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
    .resp_rdata(resp_rdata), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_mode(mem_mode), .mem_read(mem_read),
    .mem_write(mem_write), .mem_readData(mem_readData)
  );

  // ---------------- DUT with MEM_LATENCY = 3 ----------------
  logic        req_valid3, req_ready3, req_write3, req_signed3;
  logic [1:0]  req_mode3;
  logic [31:0] req_addr3, req_wdata3;
  logic        resp_valid3, resp_error3;
  logic [31:0] resp_rdata3;
  logic [31:0] mem_address3, mem_writeData3, mem_readData3;
  logic [1:0]  mem_mode3;
  logic        mem_read3, mem_write3;

  load_store_unit #(.MEM_LATENCY(LAT3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_mode(req_mode3), .req_signed(req_signed3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .resp_valid(resp_valid3), .resp_error(resp_error3),
    .resp_rdata(resp_rdata3), .mem_address(mem_address3),
    .mem_writeData(mem_writeData3), .mem_mode(mem_mode3), .mem_read(mem_read3),
    .mem_write(mem_write3), .mem_readData(mem_readData3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- environment memory (shared by both DUTs) ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] env_byte(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a, input logic [1:0] m);
    case (m)
      2'b00:   return {24'h0, env_byte(a)};
      2'b01:   return {16'h0, env_byte(a), env_byte(a + 32'd1)};
      2'b10:   return {env_byte(a), env_byte(a + 32'd1), env_byte(a + 32'd2), env_byte(a + 32'd3)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic env_write(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    case (m)
      2'b00: mem[a] = d[7:0];
      2'b01: begin mem[a] = d[15:8]; mem[a + 32'd1] = d[7:0]; end
      2'b10: begin
        mem[a]         = d[31:24];
        mem[a + 32'd1] = d[23:16];
        mem[a + 32'd2] = d[15:8];
        mem[a + 32'd3] = d[7:0];
      end
      default: ;
    endcase
  endtask

  // Stores commit on every negedge the strobe is high; read data is refreshed
  // at each negedge so it is settled before the sampling posedge.
  always @(negedge clk) begin
    if (mem_write)  env_write(mem_address,  mem_mode,  mem_writeData);
    if (mem_write3) env_write(mem_address3, mem_mode3, mem_writeData3);
    mem_readData  <= env_read(mem_address,  mem_mode);
    mem_readData3 <= env_read(mem_address3, mem_mode3);
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [logic [31:0]];

  function automatic int unsigned width_bytes(input logic [1:0] m);
    return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] m, input bit s, input logic [31:0] a);
    int unsigned nb;
    longint v;
    nb = width_bytes(m);
    v = 0;
    for (int i = 0; i < int'(nb); i++)
      v = v * 256 + longint'(ref_mem.exists(a + 32'(i)) ? ref_mem[a + 32'(i)] : 8'h00);
    if (s && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
    int unsigned nb;
    nb = width_bytes(m);
    for (int i = 0; i < int'(nb); i++)
      ref_mem[a + 32'(i)] = 8'(d >> (8 * (int'(nb) - 1 - i)));
  endtask

  // Expectation for the request in flight on the latency-1 DUT. Cycle numbers
  // are cyc values seen at negedges; the accepting edge sets cyc to acc_cyc.
  bit          chk_en = 1'b0;
  bit          pend = 1'b0;
  bit          got_resp = 1'b0;
  bit          exp_err, exp_wr;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  int          exp_due, win_lo, win_hi, acc_cyc;
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_cyc;
  int          strobe_cnt = 0;
  bit          in_win;

  // Compare process: every cycle, outputs against the model's expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      in_win = pend && !exp_err && cyc >= win_lo && cyc <= win_hi;
      if (mem_read || mem_write) strobe_cnt++;
      check("req_ready", req_ready, !pend);
      check("mem_read",  mem_read,  in_win && !exp_wr);
      check("mem_write", mem_write, in_win && exp_wr);
      if (in_win) begin
        check("mem_address", mem_address, exp_addr);
        if (exp_wr) check("mem_writeData", mem_writeData, exp_wdata);
      end
      if (pend && cyc == exp_due) begin
        check("resp_valid", resp_valid, 1'b1);
        check("resp_error", resp_error, exp_err);
        check("resp_rdata", resp_rdata, exp_rdata);
        obs_rdata = resp_rdata;
        obs_err   = resp_error;
        obs_cyc   = cyc;
        got_resp  = 1'b1;
        pend      = 1'b0;
      end else begin
        check("resp_valid_idle", resp_valid, 1'b0);
        check("resp_error_idle", resp_error, 1'b0);
      end
    end
  end

  // One request on the latency-1 DUT, with random noise on req_valid while busy.
  task automatic do_req(input bit w, input logic [1:0] m, input bit s,
                        input logic [31:0] a, input logic [31:0] d);
    int n;
    bit err, garbage;
    err = (m == 2'b11) || (m == 2'b01 && a[0]) || (m == 2'b10 && a[1:0] != 2'b00);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin fail_now("ready_timeout"); return; end
    req_valid = 1'b1; req_write = w; req_mode = m; req_signed = s;
    req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    acc_cyc    = cyc;
    strobe_cnt = 0;
    got_resp   = 1'b0;
    exp_err    = err;
    exp_wr     = w;
    exp_addr   = a;
    exp_wdata  = d;
    exp_due    = err ? cyc : cyc + LAT1;
    win_lo     = cyc;
    win_hi     = cyc + LAT1 - 1;
    exp_rdata  = 32'h0;
    if (!err) begin
      if (w) ref_store(m, a, d);
      else   exp_rdata = ref_load(m, s, a);
    end
    pend = 1'b1;
    garbage = ($urandom_range(0, 1) == 1);
    n = 0;
    while (!got_resp && n < 20) begin
      @(negedge clk);
      n++;
      if (req_ready || !garbage) req_valid = 1'b0;
      else begin
        req_valid  = 1'b1;
        req_write  = 1'($urandom_range(0, 1));
        req_mode   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
    end
    req_valid = 1'b0;
    if (!got_resp) begin fail_now("resp_timeout"); pend = 1'b0; end
  endtask

  // One request on the latency-3 DUT while req_valid stays high with another
  // request during the whole busy period.
  task automatic run3(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_data);
    int n, n0, rd_cnt, wr_cnt, resp_cnt, resp_at;
    logic [31:0] got;
    n = 0;
    @(negedge clk);
    while (!req_ready3 && n < 20) begin @(negedge clk); n++; end
    if (!req_ready3) begin fail_now("ready3_timeout"); return; end
    req_valid3 = 1'b1; req_write3 = w; req_mode3 = 2'b10; req_signed3 = 1'b0;
    req_addr3 = a; req_wdata3 = d;
    @(posedge clk); #1;
    n0 = cyc;
    req_addr3 = 32'h0000_0044; req_write3 = ~w; req_wdata3 = 32'h5555_5555;
    rd_cnt = 0; wr_cnt = 0; resp_cnt = 0; resp_at = -1; got = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready3) req_valid3 = 1'b0;
      if (mem_read3)  rd_cnt++;
      if (mem_write3) wr_cnt++;
      if (resp_valid3) begin resp_cnt++; resp_at = cyc - n0; got = resp_rdata3; end
    end
    req_valid3 = 1'b0;
    check("lat3_read_cycles",  rd_cnt, w ? 0 : 3);
    check("lat3_write_cycles", wr_cnt, w ? 3 : 0);
    check("lat3_resp_pulses",  resp_cnt, 1);
    // Response lies in the 4th cycle after the accepting edge.
    check("lat3_resp_cycle",   resp_at, 3);
    check("lat3_rdata",        got, exp_data);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_mode = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    req_valid3 = 0; req_write3 = 0; req_mode3 = 0; req_signed3 = 0; req_addr3 = 0; req_wdata3 = 0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_req_ready",  req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_error", resp_error, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr",   mem_address, 32'h0);
    check("rst_mem_wdata",  mem_writeData, 32'h0);
    check("rst_mem_mode",   mem_mode, 2'b00);
    check("rst_mem_read",   mem_read, 1'b0);
    check("rst_mem_write",  mem_write, 1'b0);
    check("rst_req_ready3", req_ready3, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Directed cases, each also pinned to a hand-computed value.
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h1122_3344);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    check("lw_100", obs_rdata, 32'h1122_3344);
    check("lw_100_err", obs_err, 1'b0);
    check("lw_latency", obs_cyc - acc_cyc, 1);
    do_req(1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
    check("lb_100", obs_rdata, 32'h0000_0011);
    do_req(1'b1, 2'b00, 1'b0, 32'h104, 32'hABCD_EF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h104, 32'h0);
    check("lb_104_signed", obs_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'b00, 1'b0, 32'h104, 32'h0);
    check("lbu_104", obs_rdata, 32'h0000_0080);
    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_F00D);
    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    check("lh_102_signed", obs_rdata, 32'hFFFF_F00D);
    do_req(1'b0, 2'b01, 1'b1, 32'h101, 32'h0);
    check("lh_101_err", obs_err, 1'b1);
    check("lh_101_no_strobe", strobe_cnt, 0);
    check("lh_101_err_cycle", obs_cyc - acc_cyc, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h202, 32'hDEAD_BEEF);
    check("sw_202_err", obs_err, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    check("lw_200_untouched", obs_rdata, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    check("mode3_err", obs_err, 1'b1);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hA5A5_5A5A);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    check("lw_top", obs_rdata, 32'hA5A5_5A5A);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] base;
      logic [1:0]  m;
      case ($urandom_range(0, 2))
        0:       base = 32'h100;
        1:       base = 32'h200;
        default: base = 32'hFFFF_FFF8;
      endcase
      m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)),
             base + 32'($urandom_range(0, 7)), $urandom);
    end

    // MEM_LATENCY=3 instance.
    run3(1'b1, 32'h40, 32'hCAFE_BABE, 32'h0);
    check("lat3_mem_40", env_read(32'h40, 2'b10), 32'hCAFE_BABE);
    run3(1'b0, 32'h40, 32'h0, 32'hCAFE_BABE);

    // Reset in the first half of a store's ACCESS cycle.
    chk_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_mode = 2'b10; req_signed = 1'b0;
    req_addr = 32'h300; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_strobe_before", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_mem_write", mem_write, 1'b0);
    check("rst_mid_mem_read",  mem_read, 1'b0);
    check("rst_mid_resp",      resp_valid, 1'b0);
    check("rst_mid_rdata",     resp_rdata, 32'h0);
    check("rst_mid_addr",      mem_address, 32'h0);
    check("rst_mid_ready",     req_ready, 1'b1);
    @(negedge clk); #1;
    check("rst_mid_mem_300", env_read(32'h300, 2'b10), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_pulse", resp_valid, 1'b0);
    end
    chk_en = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    check("lw_300_after_abort", obs_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
